// File: rtl/hall98_exec_unit.sv
// Small multi-cycle execution unit: register file, data memory, MOV/ADD/SUB/MUL/LDR/STR.
// Optional iterative multiplier is built when HALL98_MUL_EN is defined.
module hall98_exec_unit #(
  parameter  int WIDTH     = 32,
  parameter  int NREGS     = 8,
  parameter  int MEM_DEPTH = 16,
  localparam int RAW       = $clog2(NREGS),
  localparam int MAW       = $clog2(MEM_DEPTH)
) (
  input  logic             iclock,
  input  logic             ireset_n,
  input  logic [31:0]      opcode,
  input  logic [RAW-1:0]   re,
  input  logic [WIDTH-1:0] n,
  input  logic             valid,
  input  logic             flag,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err,
  output logic             halted
);

  localparam logic [7:0] OP_MOV = 8'h45;
  localparam logic [7:0] OP_ADD = 8'h46;
  localparam logic [7:0] OP_SUB = 8'h47;
  localparam logic [7:0] OP_LDR = 8'h49;
  localparam logic [7:0] OP_STR = 8'h4A;
`ifdef HALL98_MUL_EN
  localparam logic [7:0] OP_MUL = 8'h48;
  localparam int         CW     = $clog2(WIDTH);
`endif
  localparam logic [WIDTH-1:0] MEM_LIMIT = WIDTH'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
`ifdef HALL98_MUL_EN
    MULT,
`endif
    HALT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [RAW-1:0]   re_q, re_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] mem_q  [MEM_DEPTH];
  logic [WIDTH-1:0] mem_d  [MEM_DEPTH];
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             halt_req_q, halt_req_d;
`ifdef HALL98_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`endif

  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum_w;
  logic             in_range;
  logic [MAW-1:0]   mem_addr;
  logic             unused_opcode_hi;

  // Operands are read in EXEC, before the writeback edge, so re == n sees the old value twice.
  assign op_a             = regs_q[re_q];
  assign op_b             = regs_q[n_q[RAW-1:0]];
  assign in_range         = (n_q < MEM_LIMIT);
  assign mem_addr         = n_q[MAW-1:0];
  assign unused_opcode_hi = ^opcode[31:8];

  assign ready  = (state_q == IDLE) && !flag;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign err    = err_q;
  assign halted = (state_q == HALT);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d    = state_q;
    op_d       = op_q;
    re_d       = re_q;
    n_d        = n_q;
    regs_d     = regs_q;
    mem_d      = mem_q;
    result_d   = result_q;
    carry_d    = carry_q;
    err_d      = 1'b0;
    done_d     = 1'b0;
    halt_req_d = halt_req_q;
    sum_w      = '0;
`ifdef HALL98_MUL_EN
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (flag) begin
          state_d = HALT;
        end else if (valid) begin
          op_d       = opcode[7:0];
          re_d       = re;
          n_d        = n;
          halt_req_d = 1'b0;
          state_d    = EXEC;
`ifdef HALL98_MUL_EN
          if (opcode[7:0] == OP_MUL) begin
            state_d  = MULT;
            mcand_d  = regs_q[re];
            mplier_d = regs_q[n[RAW-1:0]];
            acc_d    = '0;
            cnt_d    = '0;
          end
`endif
        end
      end
`ifdef HALL98_MUL_EN
      MULT: begin
        halt_req_d = halt_req_q | flag;
        acc_d      = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d    = mcand_q << 1;
        mplier_d   = mplier_q >> 1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = EXEC;
      end
`endif
      EXEC: begin
        done_d  = 1'b1;
        state_d = (flag || halt_req_q) ? HALT : IDLE;
        case (op_q)
          OP_MOV: begin
            regs_d[re_q] = n_q;
            result_d     = n_q;
          end
          OP_ADD: begin
            sum_w        = {1'b0, op_a} + {1'b0, op_b};
            regs_d[re_q] = sum_w[WIDTH-1:0];
            result_d     = sum_w[WIDTH-1:0];
            carry_d      = sum_w[WIDTH];
          end
          OP_SUB: begin
            sum_w        = {1'b0, op_a} - {1'b0, op_b};
            regs_d[re_q] = sum_w[WIDTH-1:0];
            result_d     = sum_w[WIDTH-1:0];
            carry_d      = sum_w[WIDTH];
          end
`ifdef HALL98_MUL_EN
          OP_MUL: begin
            regs_d[re_q] = acc_q;
            result_d     = acc_q;
          end
`endif
          OP_LDR: begin
            if (in_range) begin
              regs_d[re_q] = mem_q[mem_addr];
              result_d     = mem_q[mem_addr];
            end else begin
              err_d = 1'b1;
            end
          end
          OP_STR: begin
            if (in_range) begin
              mem_d[mem_addr] = op_a;
              result_d        = op_a;
            end else begin
              err_d = 1'b1;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the register file and memory sit in flops with the async reset because reset must zero them.
  always_ff @(posedge iclock or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      re_q       <= '0;
      n_q        <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      halt_req_q <= 1'b0;
`ifdef HALL98_MUL_EN
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      op_q       <= op_d;
      re_q       <= re_d;
      n_q        <= n_d;
      regs_q     <= regs_d;
      mem_q      <= mem_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      err_q      <= err_d;
      done_q     <= done_d;
      halt_req_q <= halt_req_d;
`ifdef HALL98_MUL_EN
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_hall98_exec_unit.sv
// Self-checking bench for hall98_exec_unit: vector table with scoreboard plus reset/halt sequences.
module tb_hall98_exec_unit;
  localparam int WIDTH = 32;
  localparam int NREGS = 8;
  localparam int MEM_DEPTH = 16;

  logic        iclock = 1'b0;
  logic        ireset_n = 1'b0;
  logic [31:0] opcode = '0;
  logic [2:0]  re = '0;
  logic [31:0] n = '0;
  logic        valid = 1'b0;
  logic        flag = 1'b0;
  logic        ready, done, carry, err, halted;
  logic [31:0] result;

  hall98_exec_unit #(.WIDTH(WIDTH), .NREGS(NREGS), .MEM_DEPTH(MEM_DEPTH)) dut (
    .iclock(iclock), .ireset_n(ireset_n), .opcode(opcode), .re(re), .n(n),
    .valid(valid), .flag(flag), .ready(ready), .done(done), .result(result),
    .carry(carry), .err(err), .halted(halted)
  );

  always #5 iclock = ~iclock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] op;
    logic [2:0]  rd;
    logic [31:0] nv;
    logic [31:0] res;
    logic        c;
    logic        e;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        e;
    int          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(input logic [31:0] op, input logic [2:0] rd, input logic [31:0] nv,
                              input logic [31:0] res, input logic c, input logic e, input int lat);
    vec_t v;
    v.op = op; v.rd = rd; v.nv = nv; v.res = res; v.c = c; v.e = e; v.lat = lat;
    vecs.push_back(v);
  endfunction

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!ready && w < 50) begin
      @(posedge iclock); #1;
      w++;
    end
    if (!ready) check({tag, " ready"}, {31'b0, ready}, 32'd1);
  endtask

  task automatic run(input vec_t v, input string tag);
    int   lat = 0;
    int   rlow;
    exp_t e;
    wait_ready(tag);
    sb.push_back('{v.res, v.c, v.e, v.lat});
    opcode = v.op; re = v.rd; n = v.nv; valid = 1'b1;
    @(posedge iclock); #1;
    valid = 1'b0;
    rlow = ready ? 0 : 1;
    check({tag, " pulse"}, {31'b0, done}, 32'd0);
    while (!done && lat < 100) begin
      @(posedge iclock); #1;
      lat++;
      if (!ready) rlow++;
    end
    e = sb.pop_front();
    if (!done) begin
      check({tag, " done timeout"}, {31'b0, done}, 32'd1);
    end else begin
      check({tag, " result"}, result, e.res);
      check({tag, " carry"}, {31'b0, carry}, {31'b0, e.c});
      check({tag, " err"}, {31'b0, err}, {31'b0, e.e});
      check({tag, " latency"}, 32'(lat), 32'(e.lat));
      check({tag, " ready_low"}, 32'(rlow), 32'(e.lat));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " done"}, {31'b0, done}, 32'd0);
    check({tag, " result"}, result, 32'd0);
    check({tag, " carry"}, {31'b0, carry}, 32'd0);
    check({tag, " err"}, {31'b0, err}, 32'd0);
    check({tag, " halted"}, {31'b0, halted}, 32'd0);
  endtask

  initial begin
    bit seen_done, seen_ready;

    // Opcode upper bits are deliberately non-zero on some entries: only [7:0] decodes.
    add(32'hABCD_0045, 3'd2, 32'd15,          32'd15,          1'b0, 1'b0, 1);
    add(32'h0000_0045, 3'd3, 32'd5,           32'd5,           1'b0, 1'b0, 1);
    add(32'h0000_0046, 3'd2, 32'd3,           32'd20,          1'b0, 1'b0, 1);
    add(32'h0000_0047, 3'd2, 32'd3,           32'd15,          1'b0, 1'b0, 1);
    add(32'h0000_004A, 3'd3, 32'd4,           32'd5,           1'b0, 1'b0, 1);
    add(32'h0000_0045, 3'd3, 32'd0,           32'd0,           1'b0, 1'b0, 1);
    add(32'h0000_0049, 3'd3, 32'd4,           32'd5,           1'b0, 1'b0, 1);
    add(32'h0000_0049, 3'd3, 32'd16,          32'd5,           1'b0, 1'b1, 1);
    add(32'h0000_004A, 3'd3, 32'd0,           32'd5,           1'b0, 1'b0, 1);
    add(32'h0000_0045, 3'd4, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b0, 1'b0, 1);
    add(32'h0000_0045, 3'd5, 32'd1,           32'd1,           1'b0, 1'b0, 1);
    add(32'h0000_0046, 3'd4, 32'd5,           32'd0,           1'b1, 1'b0, 1);
    add(32'h0000_0045, 3'd6, 32'd0,           32'd0,           1'b1, 1'b0, 1);
    add(32'h0000_0047, 3'd6, 32'd5,           32'hFFFF_FFFF,   1'b1, 1'b0, 1);
    add(32'h0000_0046, 3'd6, 32'd6,           32'hFFFF_FFFE,   1'b1, 1'b0, 1);
    add(32'h0000_0047, 3'd5, 32'd5,           32'd0,           1'b0, 1'b0, 1);
    add(32'h0000_0000, 3'd1, 32'd0,           32'd0,           1'b0, 1'b1, 1);
    add(32'h0000_004B, 3'd1, 32'd0,           32'd0,           1'b0, 1'b1, 1);
    add(32'h0000_004A, 3'd3, 32'hFFFF_0004,   32'd0,           1'b0, 1'b1, 1);
`ifdef HALL98_MUL_EN
    add(32'h0000_0048, 3'd2, 32'd3,           32'd75,          1'b0, 1'b0, 33);
    add(32'h0000_0045, 3'd2, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b0, 1'b0, 1);
    add(32'h0000_0045, 3'd7, 32'd2,           32'd2,           1'b0, 1'b0, 1);
    add(32'h0000_0048, 3'd2, 32'd7,           32'hFFFF_FFFE,   1'b0, 1'b0, 33);
    add(32'h0000_0048, 3'd7, 32'd7,           32'd4,           1'b0, 1'b0, 33);
`else
    add(32'h0000_0048, 3'd2, 32'd3,           32'd0,           1'b0, 1'b1, 1);
    add(32'h0000_004A, 3'd2, 32'd1,           32'd15,          1'b0, 1'b0, 1);
`endif
    add(32'h0000_0045, 3'd4, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   1'b0, 1'b0, 1);
    add(32'h0000_0045, 3'd5, 32'd1,           32'd1,           1'b0, 1'b0, 1);
    add(32'h0000_0046, 3'd4, 32'd5,           32'd0,           1'b1, 1'b0, 1);
    add(32'h0000_0045, 3'd6, 32'h0000_1234,   32'h0000_1234,   1'b1, 1'b0, 1);

    #1;
    check_cleared("reset0");
    check("reset0 ready", {31'b0, ready}, 32'd1);
    repeat (2) @(posedge iclock);
    #1 ireset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-instruction: no done and all outputs cleared while held.
    wait_ready("rst_seq");
`ifdef HALL98_MUL_EN
    opcode = 32'h48; re = 3'd2; n = 32'd3; valid = 1'b1;
    @(posedge iclock); #1 valid = 1'b0;
    repeat (4) @(posedge iclock);
    #1;
`else
    opcode = 32'h46; re = 3'd2; n = 32'd3; valid = 1'b1;
    @(posedge iclock); #1 valid = 1'b0;
`endif
    ireset_n = 1'b0;
    #1;
    check_cleared("rst_hold");
    seen_done = 1'b0;
    repeat (5) begin
      @(posedge iclock); #1;
      if (done) seen_done = 1'b1;
    end
    check("rst_hold no_done", {31'b0, seen_done}, 32'd0);
    check("rst_hold ready", {31'b0, ready}, 32'd1);
    ireset_n = 1'b1;

    run('{32'h45, 3'd1, 32'd7, 32'd7, 1'b0, 1'b0, 1}, "post_rst mov");
    run('{32'h4A, 3'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1}, "post_rst reg_clear");
    run('{32'h49, 3'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1}, "post_rst mem_clear");

    // Halt requested while an instruction executes: it completes, then HALT.
    wait_ready("halt_exec");
    opcode = 32'h46; re = 3'd1; n = 32'd1; valid = 1'b1;
    @(posedge iclock); #1 valid = 1'b0;
    flag = 1'b1;
    @(posedge iclock); #1;
    check("halt_exec done", {31'b0, done}, 32'd1);
    check("halt_exec result", result, 32'd14);
    check("halt_exec halted", {31'b0, halted}, 32'd1);
    flag = 1'b0;
    @(posedge iclock); #1;
    check("halt_exec sticky", {31'b0, halted}, 32'd1);
    check("halt_exec ready", {31'b0, ready}, 32'd0);
    ireset_n = 1'b0;
    #1 check("halt_exec reset", {31'b0, halted}, 32'd0);
    @(posedge iclock); #1 ireset_n = 1'b1;

    // valid and flag together in IDLE: flag wins, then valid is ignored while halted.
    opcode = 32'h45; re = 3'd1; n = 32'd9; valid = 1'b1; flag = 1'b1;
    #1 check("halt_idle ready", {31'b0, ready}, 32'd0);
    @(posedge iclock); #1;
    check("halt_idle halted", {31'b0, halted}, 32'd1);
    check("halt_idle done", {31'b0, done}, 32'd0);
    flag = 1'b0;
    seen_done = 1'b0;
    seen_ready = 1'b0;
    repeat (10) begin
      @(posedge iclock); #1;
      if (done) seen_done = 1'b1;
      if (ready) seen_ready = 1'b1;
    end
    valid = 1'b0;
    check("halt_idle no_done", {31'b0, seen_done}, 32'd0);
    check("halt_idle no_ready", {31'b0, seen_ready}, 32'd0);
    check("halt_idle still", {31'b0, halted}, 32'd1);
    check("halt_idle result", result, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
